rr_arbiter_hold: RTL and testbench
==================================

Name: rr_arbiter_hold

Overview:
- Parameterised, registered round-robin arbiter. Successor to the team's combinational fixed-priority arbiter (day14).
- Adds fairness via a rotating priority pointer and grant locking: a requester keeps the grant while its request stays high.
- Adds a bounded hold time so no port can starve the others.
- Sits in front of shared resources (bus master select, shared memory port) with NUM_PORTS requesters.

Parameters:
- NUM_PORTS, 17, number of requesters (>=2).
- MAX_HOLD, 8, max consecutive cycles one grant is held while other requests pend (>=1).
- IDX_W, $clog2(NUM_PORTS), width of the grant index output (derived; not overridden).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_i  in  NUM_PORTS  request vector, bit i = port i.
- gnt_o  out  NUM_PORTS  registered one-hot grant, all-zero when idle.
- gnt_valid_o  out  1  high when any grant is active (= |gnt_o).
- gnt_idx_o  out  IDX_W  index of granted port; 0 when idle.
- preempt_o  out  1  one-cycle pulse on the cycle after a grant is revoked by hold timeout.

Behaviour:
- Reset (async, active-high):
  - gnt_o=0, gnt_valid_o=0, gnt_idx_o=0, preempt_o=0.
  - State=IDLE, pointer=0, hold_cnt=0.
- States:
  - IDLE: no grant.
  - GRANT: one port holds the grant.
- Arbitration function:
  - Search req_i starting at index pointer, ascending with wrap-around modulo NUM_PORTS.
  - The first set bit wins.
- IDLE -> GRANT:
  - Any req_i bit high at a rising edge: winner registered into gnt_o at that edge.
  - Latency: request first high in cycle N, grant visible in cycle N+1.
  - pointer <= winner+1 (wraps to 0 after NUM_PORTS-1). hold_cnt <= 0.
- GRANT, hold:
  - Granted port's req stays high, and either hold_cnt < MAX_HOLD-1 or no other req is set.
  - Grant unchanged. hold_cnt increments, saturating at MAX_HOLD-1.
- GRANT, release:
  - Granted port's req low at an edge: rearbitrate in the same edge using the current pointer.
  - If another request exists, the grant moves directly to it (no dead cycle) and hold_cnt resets.
  - Otherwise go to IDLE with gnt_o=0.
- GRANT, timeout:
  - Granted port's req high, hold_cnt == MAX_HOLD-1, and at least one other req set.
  - At the edge, grant moves to the winner among the other ports. The current holder is excluded, and the pointer is already past it.
  - preempt_o=1 for exactly the next cycle. hold_cnt resets.
- Simultaneous release and timeout: treated as release; no preempt_o pulse.
- Grant invariants:
  - gnt_o is always one-hot or zero.
  - A granted bit is never set for a port whose req was low at the granting edge.
- MAX_HOLD=1: any pending competitor preempts every cycle, giving pure per-cycle round-robin.
- Reset mid-grant: outputs clear immediately (asynchronously). The first grant after reset searches from port 0.
- Pointer wrap: a winner at NUM_PORTS-1 sets pointer=0. Non-power-of-two NUM_PORTS is supported; indices >= NUM_PORTS are never produced.

Optional Feature:
- Macro: RR_ARB_PRIO_EN.
- When defined:
  - Adds input prio_i [NUM_PORTS]; a set bit marks that port's request as high-class.
  - Arbitration (initial grant, release, timeout) considers only high-class requesters if any exist, round-robin among them with the shared pointer.
  - Otherwise all requesters are considered.
  - Timeout preemption is triggered only by competitors of equal or higher class than the holder.
  - A high-class request pending during a low-class grant forces preemption after at most MAX_HOLD cycles regardless of hold_cnt saturation.
- When undefined: no prio_i port; behaviour exactly as above.

Test Plan:
- Round-robin, no hold (NUM_PORTS=4, MAX_HOLD=4):
  - Stimulus: req_i=4'b1111 held, holder's req dropped one cycle after each grant.
  - Required: grants cycle port 0,1,2,3,0, with gnt_idx_o 0,1,2,3,0.
- Latency/idle:
  - Stimulus: req_i=0 for 3 cycles, then req_i=4'b0100 at cycle N.
  - Required: gnt_o=0 through cycle N, gnt_o=4'b0100 and gnt_idx_o=2 at N+1; after req drops, gnt_o=0 the following cycle.
- Hold timeout:
  - Stimulus: port 1 requests continuously and is granted; port 3 asserts 2 cycles later.
  - Required: port 1 keeps the grant for exactly 4 cycles; grant switches to port 3 (4'b1000) on the 5th; preempt_o=1 for one cycle.
- Lone holder:
  - Stimulus: only port 0 requests for 20 cycles.
  - Required: grant never changes; preempt_o stays 0.
- Wrap and non-power-of-two (NUM_PORTS=17):
  - Stimulus: port 16 granted and released, then req on ports 0 and 5.
  - Required: port 0 granted next (pointer wrapped); gnt_idx_o never exceeds 16.
- Async reset:
  - Stimulus: reset asserted mid-grant between clock edges.
  - Required: gnt_o, gnt_valid_o, preempt_o are 0 immediately; after release with req_i=4'b1010, port 1 is granted first.

Source files
------------

// File: rtl/rr_arbiter_hold.sv
// rr_arbiter_hold: registered round-robin arbiter with grant locking and a
// bounded hold time. A holder keeps the grant while its request stays high,
// but is preempted after MAX_HOLD consecutive cycles if anyone else waits.
// Optional build macro RR_ARB_PRIO_EN adds a prio_i port: high-class
// requesters are arbitrated ahead of low-class ones, and a high-class holder
// can only be timed out by another high-class requester.
module rr_arbiter_hold #(
    parameter int NUM_PORTS = 17,
    parameter int MAX_HOLD  = 8,
    parameter int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_PORTS-1:0] req_i,
`ifdef RR_ARB_PRIO_EN
    input  logic [NUM_PORTS-1:0] prio_i,
`endif
    output logic [NUM_PORTS-1:0] gnt_o,
    output logic                 gnt_valid_o,
    output logic [IDX_W-1:0]     gnt_idx_o,
    output logic                 preempt_o
);

    localparam int                HOLD_W   = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t               state_q, state_d;
    logic [NUM_PORTS-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic                 preempt_q, preempt_d;

    logic [NUM_PORTS-1:0] others;   // requesters other than the current holder
    logic [NUM_PORTS-1:0] arb_in;   // candidates fed to the rotating search
    logic [NUM_PORTS-1:0] rivals;   // competitors allowed to force a timeout
    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    logic                 take;

    // (base + k) mod NUM_PORTS; never yields an index >= NUM_PORTS
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_PORTS) s = s - NUM_PORTS;
        return s[IDX_W-1:0];
    endfunction

    // The holder's own bit is masked out, so one search serves initial grant,
    // release (holder's req is low anyway) and timeout (holder excluded).
    always_comb begin
        others = req_i & ~gnt_q;
`ifdef RR_ARB_PRIO_EN
        arb_in = (|(others & prio_i)) ? (others & prio_i) : others;
        rivals = prio_i[idx_q] ? (others & prio_i) : others;
`else
        arb_in = others;
        rivals = others;
`endif
    end

    // Rotating search: first candidate at or after the pointer, with wrap
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!win_found && arb_in[wrap_add(ptr_q, k)]) begin
                win_found = 1'b1;
                win_idx   = wrap_add(ptr_q, k);
            end
        end
    end

    // State register: grant, pointer, hold counter and preempt pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            idx_q     <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            preempt_q <= preempt_d;
        end
    end

    // Next state: grant / hold / release / timeout decisions
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        preempt_d = 1'b0;
        take      = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found) take = 1'b1;
            end
            GRANT: begin
                if (!req_i[idx_q]) begin
                    // release wins over a coincident timeout: no preempt pulse
                    if (win_found) begin
                        take = 1'b1;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        idx_d   = '0;
                        hold_d  = '0;
                    end
                end else if (hold_q == HOLD_MAX && |rivals) begin
                    take      = 1'b1;
                    preempt_d = 1'b1;
                end else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + 1'b1;
                end
            end
        endcase
        if (take) begin
            state_d        = GRANT;
            gnt_d          = '0;
            gnt_d[win_idx] = 1'b1;
            idx_d          = win_idx;
            ptr_d          = wrap_add(win_idx, 1);
            hold_d         = '0;
        end
    end

    // Outputs come straight from registers
    always_comb begin
        gnt_o       = gnt_q;
        gnt_valid_o = |gnt_q;
        gnt_idx_o   = idx_q;
        preempt_o   = preempt_q;
    end

endmodule

// File: tb/tb_rr_arbiter_hold.sv
// Bench for rr_arbiter_hold: a 4-port/MAX_HOLD=4 instance and a 17-port
// instance driven together. Each stimulus cycle pushes the reference model's
// expected outputs; a monitor pops and compares after every clock edge.
module tb_rr_arbiter_hold;

    typedef struct { int holder; int ptr; int held; } mst_t;
    typedef struct { logic [31:0] gnt; int idx; bit pre; } exp_t;

    logic        clk, reset;
    logic [3:0]  req4, gnt4;
    logic [1:0]  idx4;
    logic        v4, p4;
    logic [16:0] req17, gnt17;
    logic [4:0]  idx17;
    logic        v17, p17;

    int   n_chk  = 0;
    int   n_pass = 0;
    mst_t m4     = '{holder: -1, ptr: 0, held: 0};
    mst_t m17    = '{holder: -1, ptr: 0, held: 0};
    exp_t q4[$];
    exp_t q17[$];

    rr_arbiter_hold #(.NUM_PORTS(4), .MAX_HOLD(4)) dut4 (
        .clk(clk), .reset(reset), .req_i(req4),
`ifdef RR_ARB_PRIO_EN
        .prio_i('0),
`endif
        .gnt_o(gnt4), .gnt_valid_o(v4), .gnt_idx_o(idx4), .preempt_o(p4)
    );

    rr_arbiter_hold #(.NUM_PORTS(17), .MAX_HOLD(8)) dut17 (
        .clk(clk), .reset(reset), .req_i(req17),
`ifdef RR_ARB_PRIO_EN
        .prio_i('0),
`endif
        .gnt_o(gnt17), .gnt_valid_o(v17), .gnt_idx_o(idx17), .preempt_o(p17)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    endtask

    // First requester at or after ptr, wrapping modulo n; -1 if none
    function automatic int rr_pick(input logic [31:0] cand, input int ptr, input int n);
        for (int k = 0; k < n; k++)
            if (cand[(ptr + k) % n]) return (ptr + k) % n;
        return -1;
    endfunction

    // Reference: holder identity, cycles held so far, and search start point
    function automatic void mstep(inout mst_t s, input logic [31:0] req, input int n,
                                  input int mh, output exp_t e);
        int          w;
        bit          keep, pre;
        logic [31:0] oth;
        keep = 0; pre = 0; w = -1;
        if (s.holder < 0 || !req[s.holder]) begin
            w = rr_pick(req, s.ptr, n);
        end else begin
            oth = req;
            oth[s.holder] = 1'b0;
            if (s.held >= mh && oth != 0) begin
                w   = rr_pick(oth, s.ptr, n);
                pre = 1;
            end else begin
                keep = 1;
            end
        end
        if (keep) s.held++;
        else if (w >= 0) begin
            s.holder = w;
            s.ptr    = (w + 1) % n;
            s.held   = 1;
        end else s.holder = -1;
        e.gnt = (s.holder >= 0) ? (32'd1 << s.holder) : 32'd0;
        e.idx = (s.holder >= 0) ? s.holder : 0;
        e.pre = pre;
    endfunction

    task automatic step(input logic [3:0] r4, input logic [16:0] r17);
        exp_t e;
        @(negedge clk);
        req4  = r4;
        req17 = r17;
        mstep(m4, 32'(r4), 4, 4, e);
        q4.push_back(e);
        mstep(m17, 32'(r17), 17, 8, e);
        q17.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Monitor: compare every post-edge output against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q4.size() > 0) begin
                e = q4.pop_front();
                chk("gnt4", 32'(gnt4), e.gnt);
                chk("valid4", 32'(v4), 32'(e.gnt != 0));
                chk("idx4", 32'(idx4), 32'(e.idx));
                chk("preempt4", 32'(p4), 32'(e.pre));
            end
            if (q17.size() > 0) begin
                e = q17.pop_front();
                chk("gnt17", 32'(gnt17), e.gnt);
                chk("valid17", 32'(v17), 32'(e.gnt != 0));
                chk("idx17", 32'(idx17), 32'(e.idx));
                chk("preempt17", 32'(p17), 32'(e.pre));
                chk("idx17_range", 32'(idx17 <= 5'd16), 32'd1);
            end
        end
    end

    initial begin
        int cnt;
        reset = 1'b1;
        req4  = '0;
        req17 = '0;
        #12;
        chk("rst_gnt", 32'(gnt4), 0);
        chk("rst_valid", 32'(v4), 0);
        chk("rst_idx", 32'(idx4), 0);
        chk("rst_preempt", 32'(p4), 0);
        reset = 1'b0;

        // Round robin: holder drops its request right after each grant
        step(4'b1111, '0);
        chk("rr_idx0", 32'(idx4), 0);
        for (int i = 1; i <= 4; i++) begin
            step(4'b1111 & ~(4'b0001 << ((i - 1) % 4)), '0);
            chk("rr_idx", 32'(idx4), 32'(i % 4));
        end
        step('0, '0);

        // Latency and return to idle
        repeat (3) step('0, '0);
        chk("lat_idle", 32'(gnt4), 0);
        step(4'b0100, '0);
        chk("lat_gnt", 32'(gnt4), 32'h4);
        chk("lat_idx", 32'(idx4), 2);
        step('0, '0);
        chk("lat_release", 32'(gnt4), 0);

        // Hold timeout: port 1 holds 4 cycles, then port 3 with a preempt pulse
        cnt = 0;
        step(4'b0010, '0); if (gnt4 == 4'b0010) cnt++;
        step(4'b0010, '0); if (gnt4 == 4'b0010) cnt++;
        step(4'b1010, '0); if (gnt4 == 4'b0010) cnt++;
        step(4'b1010, '0); if (gnt4 == 4'b0010) cnt++;
        step(4'b1010, '0);
        chk("to_hold_cycles", 32'(cnt), 4);
        chk("to_gnt", 32'(gnt4), 32'h8);
        chk("to_preempt", 32'(p4), 1);
        step(4'b1010, '0);
        chk("to_preempt_pulse", 32'(p4), 0);
        step('0, '0);

        // Lone holder never loses the grant
        cnt = 0;
        repeat (20) begin
            step(4'b0001, '0);
            if (gnt4 == 4'b0001 && !p4) cnt++;
        end
        chk("lone_hold", 32'(cnt), 20);
        step('0, '0);

        // Random traffic; holders tend to keep requesting
        for (int c = 0; c < 300; c++) begin
            logic [3:0]  r4;
            logic [16:0] r17;
            r4  = 4'($urandom) & 4'($urandom);
            r17 = 17'($urandom) & 17'($urandom);
            if (m4.holder >= 0 && $urandom_range(0, 9) < 8) r4[m4.holder] = 1'b1;
            if (m17.holder >= 0 && $urandom_range(0, 9) < 8) r17[m17.holder] = 1'b1;
            step(r4, r17);
        end
        step('0, '0);

        // Pointer wrap on 17 ports
        step('0, 17'h10000);
        chk("wrap_gnt16", 32'(idx17), 16);
        step('0, '0);
        step('0, 17'h00021);
        chk("wrap_idx", 32'(idx17), 0);
        chk("wrap_gnt", 32'(gnt17), 32'h1);
        step('0, '0);

        // Asynchronous reset between edges, then search restarts at port 0
        step(4'b0100, 17'h00010);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_gnt", 32'(gnt4), 0);
        chk("arst_valid", 32'(v4), 0);
        chk("arst_preempt", 32'(p4), 0);
        chk("arst_gnt17", 32'(gnt17), 0);
        m4  = '{holder: -1, ptr: 0, held: 0};
        m17 = '{holder: -1, ptr: 0, held: 0};
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        step(4'b1010, '0);
        chk("arst_first", 32'(idx4), 1);
        step('0, '0);

        @(posedge clk);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
